// File: rtl/jtag_host_shifter.sv
// Fabric-side JTAG host: runs TLR / shift-IR / shift-DR / idle-clock commands
// against a TAP parked in Run-Test/Idle and returns the captured TDO bits.
module jtag_host_shifter #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned MAX_LEN = 32
) (
    input  logic               iclk,
    input  logic               rst_i,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [5:0]         cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               busy,
    output logic               tck_o,
    output logic               tms_o,
    output logic               tdi_o,
    input  logic               tdo_i
);

    typedef enum logic [1:0] {OP_TLR = 2'd0, OP_IR = 2'd1, OP_DR = 2'd2, OP_IDLE = 2'd3} op_t;
    typedef enum logic [2:0] {S_IDLE, S_HDR, S_SHIFT, S_TAIL, S_DONE} state_t;

    localparam int unsigned   CW       = $clog2(2 * CLK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(2 * CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_HIGH = CW'(CLK_DIV);
    localparam logic [6:0]    LEN_MAX  = 7'(MAX_LEN);

    state_t             state, state_nxt;
    op_t                op_q;
    logic [6:0]         len_q, len_eff, seg_len;
    logic [6:0]         idx, idx_nxt;
    logic [CW-1:0]      cnt, cnt_nxt;
    logic [MAX_LEN-1:0] data_q, mask_q, cap_q;
    logic               tdo_s1, tdo_s2, ready_q;
    logic               tck_nxt, tms_nxt, tdi_nxt;
    logic               accept, tck_end, last_tck, shift_nxt;

    // TMS value for TCK number k of a segment
    function automatic logic tms_at(state_t s, op_t op, logic [6:0] k, logic [6:0] len);
        logic v;
        v = 1'b0;
        case (s)
            S_HDR: begin
                case (op)
                    OP_TLR:  v = (k < 7'd5);
                    OP_IR:   v = (k < 7'd2);
                    OP_DR:   v = (k == 7'd0);
                    default: v = 1'b0;
                endcase
            end
            S_SHIFT: v = (k == len - 7'd1);
            S_TAIL:  v = (k == 7'd0);
            default: v = 1'b0;
        endcase
        return v;
    endfunction

    assign cmd_ready = ready_q && (state == S_IDLE || state == S_DONE);
    assign rsp_valid = (state == S_DONE);
    assign busy      = (state == S_HDR) || (state == S_SHIFT) || (state == S_TAIL);
    assign accept    = cmd_valid && cmd_ready;
    assign tck_end   = busy && (cnt == CNT_LAST);
    assign last_tck  = (idx == seg_len - 7'd1);

    always_comb begin
        len_eff = {1'b0, cmd_len};
        if (cmd_len == '0)
            len_eff = 7'd1;
        else if ({1'b0, cmd_len} > LEN_MAX)
            len_eff = LEN_MAX;
    end

    always_comb begin
        seg_len = 7'd1;
        case (state)
            S_HDR: begin
                case (op_q)
                    OP_TLR:  seg_len = 7'd6;
                    OP_IR:   seg_len = 7'd4;
                    OP_DR:   seg_len = 7'd3;
                    default: seg_len = len_q;
                endcase
            end
            S_SHIFT: seg_len = len_q;
            S_TAIL:  seg_len = 7'd2;
            default: seg_len = 7'd1;
        endcase
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = '0;
        tms_nxt   = tms_o;
        tdi_nxt   = tdi_o;
        shift_nxt = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                state_nxt = S_IDLE;
                if (accept) begin
                    state_nxt = S_HDR;
                    idx_nxt   = '0;
                    tms_nxt   = tms_at(S_HDR, op_t'(cmd_op), 7'd0, len_eff);
                    tdi_nxt   = 1'b0;
                end
            end
            default: begin
                cnt_nxt = cnt + CW'(1);
                if (tck_end) begin
                    cnt_nxt = '0;
                    idx_nxt = idx + 7'd1;
                    if (last_tck) begin
                        idx_nxt = '0;
                        case (state)
                            S_HDR:   state_nxt = (op_q == OP_IR || op_q == OP_DR) ? S_SHIFT : S_DONE;
                            S_SHIFT: state_nxt = S_TAIL;
                            default: state_nxt = S_DONE;
                        endcase
                    end
                    // TMS/TDI for the next TCK are launched together with its low phase
                    shift_nxt = (state_nxt == S_SHIFT);
                    tms_nxt   = tms_at(state_nxt, op_q, idx_nxt, len_q);
                    tdi_nxt   = shift_nxt ? data_q[0] : 1'b0;
                end
            end
        endcase
        tck_nxt = (state_nxt == S_HDR || state_nxt == S_SHIFT || state_nxt == S_TAIL) &&
                  (cnt_nxt >= CNT_HIGH);
    end

    always_ff @(posedge iclk or posedge rst_i) begin
        if (rst_i) begin
            state    <= S_IDLE;
            ready_q  <= 1'b0;
            idx      <= '0;
            cnt      <= '0;
            tck_o    <= 1'b0;
            tms_o    <= 1'b1;
            tdi_o    <= 1'b0;
            tdo_s1   <= 1'b0;
            tdo_s2   <= 1'b0;
            op_q     <= OP_TLR;
            len_q    <= 7'd1;
            data_q   <= '0;
            mask_q   <= '0;
            cap_q    <= '0;
            rsp_data <= '0;
        end else begin
            ready_q <= 1'b1;
            state   <= state_nxt;
            idx     <= idx_nxt;
            cnt     <= cnt_nxt;
            tck_o   <= tck_nxt;
            tms_o   <= tms_nxt;
            tdi_o   <= tdi_nxt;
            tdo_s1  <= tdo_i;
            tdo_s2  <= tdo_s1;
            if (accept) begin
                op_q   <= op_t'(cmd_op);
                len_q  <= len_eff;
                data_q <= cmd_data;
                mask_q <= {{(MAX_LEN-1){1'b0}}, 1'b1};
                cap_q  <= '0;
            end else begin
                if (shift_nxt)
                    data_q <= data_q >> 1;
                if (tck_end && state == S_SHIFT) begin
                    cap_q  <= cap_q | (mask_q & {MAX_LEN{tdo_s2}});
                    mask_q <= mask_q << 1;
                end
            end
            if (state_nxt == S_DONE)
                rsp_data <= cap_q;
        end
    end

endmodule
